// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - direct-mapped instruction cache with line refill controller
//
// Ports:
//   CLK         rising-edge clock
//   RESET       asynchronous active-low reset
//   Addr_fIF    fetch address from IF stage (bits [1:0] ignored)
//   Instr_2IF   instruction word at Addr_fIF, valid only when hit=1
//   hit         combinational lookup hit; IF advances only on hit
//   Flush       invalidate every line
//   Mem_Req     refill request, held for the whole line refill
//   Mem_Addr    word address currently requested (0 when idle)
//   Mem_Ack     Mem_Data carries the requested word this cycle
//   Mem_Data    refill data
//   Miss_Count  saturating count of refills started
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Addr_fIF,
    output logic [31:0] Instr_2IF,
    output logic        hit,
    input  logic        Flush,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Data,
    output logic [31:0] Miss_Count
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state;
    state_t next_state;

    logic [31:0]          data_arr [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [OFF_W-1:0]     counter;
    logic [31:0]          line_base;
    logic                 flush_pending;
    logic [31:0]          miss_count;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] refill_idx;
    logic [TAG_W-1:0] refill_tag;
    logic             lookup_hit;
    logic             start_refill;
    logic             take_ack;
    logic             final_ack;
    logic             unused_byte_bits;

    assign req_off    = Addr_fIF[IDX_LSB-1:2];
    assign req_idx    = Addr_fIF[TAG_LSB-1:IDX_LSB];
    assign req_tag    = Addr_fIF[31:TAG_LSB];
    assign refill_idx = line_base[TAG_LSB-1:IDX_LSB];
    assign refill_tag = line_base[31:TAG_LSB];

    // Byte-within-word bits never take part in instruction fetch.
    assign unused_byte_bits = ^Addr_fIF[1:0];

    assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign Instr_2IF  = data_arr[req_idx][req_off];
    assign Miss_Count = miss_count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        Mem_Req    = 1'b0;
        Mem_Addr   = 32'd0;
        hit        = 1'b0;
        case (state)
            IDLE: begin
                hit = lookup_hit && !Flush;
                // A flush in the same cycle wins over starting a refill.
                if (!Flush && !lookup_hit) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                Mem_Req  = 1'b1;
                Mem_Addr = line_base + {{(30 - OFF_W){1'b0}}, counter, 2'b00};
                if (Mem_Ack && (counter == LAST_WORD)) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

    assign start_refill = (state == IDLE) && (next_state == REFILL);
    assign take_ack     = (state == REFILL) && Mem_Ack;
    assign final_ack    = take_ack && (counter == LAST_WORD);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            counter       <= '0;
            line_base     <= 32'd0;
            flush_pending <= 1'b0;
            valid         <= '0;
            miss_count    <= 32'd0;
        end else begin
            if (start_refill) begin
                // Latch the line so a redirect on Addr_fIF cannot disturb the refill.
                line_base <= {Addr_fIF[31:IDX_LSB], {IDX_LSB{1'b0}}};
                counter   <= '0;
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end else if (take_ack) begin
                counter <= counter + OFF_W'(1);
            end

            // A flush during or coincident with the refill keeps the new line invalid.
            if (Flush) begin
                valid <= '0;
            end else if (final_ack && !flush_pending) begin
                valid[refill_idx] <= 1'b1;
            end

            if (final_ack) begin
                flush_pending <= 1'b0;
            end else if (Flush && (state == REFILL)) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // Payload arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge CLK) begin
        if (take_ack) begin
            data_arr[refill_idx][counter] <= Mem_Data;
        end
        if (final_ack) begin
            tag_arr[refill_idx] <= refill_tag;
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    localparam int LW = 4;
    localparam int NL = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] Addr_fIF;
    logic [31:0] Instr_2IF;
    logic        hit;
    logic        Flush;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_Data;
    logic [31:0] Miss_Count;

    icache_refill_ctrl #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Addr_fIF   (Addr_fIF),
        .Instr_2IF  (Instr_2IF),
        .hit        (hit),
        .Flush      (Flush),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .Mem_Ack    (Mem_Ack),
        .Mem_Data   (Mem_Data),
        .Miss_Count (Miss_Count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Line-level cache model: what each line holds, its tag and validity.
    logic [31:0] m_data  [NL][LW];
    logic [31:0] m_tag   [NL];
    bit          m_valid [NL];
    logic [31:0] m_miss;
    logic [31:0] lbuf    [LW];

    task automatic check32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 16) % NL);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && (m_tag[line_of(a)] == (a / 1024));
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return m_data[line_of(a)][int'((a / 4) % LW)];
    endfunction

    task automatic model_flush();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic fill_lbuf();
        for (int w = 0; w < LW; w++) lbuf[w] = $urandom;
    endtask

    task automatic begin_refill(input logic [31:0] a);
        Addr_fIF = a;
        #1;
        check32("miss_hit", 32'(hit), 32'd0);
        check32("idle_req", 32'(Mem_Req), 32'd0);
        check32("idle_addr", Mem_Addr, 32'd0);
        tick();
        m_miss = m_miss + 32'd1;
        check32("refill_req", 32'(Mem_Req), 32'd1);
        check32("miss_count", Miss_Count, m_miss);
    endtask

    task automatic serve_word(input logic [31:0] base, input int w, input int gap, input bit fl);
        logic [31:0] ea;
        ea = base + 32'(4 * w);
        for (int g = 0; g < gap; g++) begin
            check32("gap_addr", Mem_Addr, ea);
            tick();
        end
        check32("refill_hit", 32'(hit), 32'd0);
        check32("word_req", 32'(Mem_Req), 32'd1);
        check32("word_addr", Mem_Addr, ea);
        Mem_Ack  = 1'b1;
        Mem_Data = lbuf[w];
        Flush    = fl;
        tick();
        Mem_Ack  = 1'b0;
        Flush    = 1'b0;
        Mem_Data = $urandom;
    endtask

    task automatic finish_refill(input logic [31:0] a, input bit flushed);
        check32("done_req", 32'(Mem_Req), 32'd0);
        check32("done_addr", Mem_Addr, 32'd0);
        for (int w = 0; w < LW; w++) m_data[line_of(a)][w] = lbuf[w];
        m_tag[line_of(a)] = a / 1024;
        if (!flushed) m_valid[line_of(a)] = 1'b1;
    endtask

    task automatic access(input logic [31:0] a, input int gmin, input int gmax, input bit fixed);
        logic [31:0] base;
        Addr_fIF = a;
        #1;
        if (model_hit(a)) begin
            check32("hit", 32'(hit), 32'd1);
            check32("instr", Instr_2IF, model_word(a));
            tick();
        end else begin
            base = a - (a % 16);
            if (!fixed) fill_lbuf();
            begin_refill(a);
            for (int w = 0; w < LW; w++)
                serve_word(base, w, int'($urandom_range(gmax, gmin)), 1'b0);
            finish_refill(a, 1'b0);
            check32("post_hit", 32'(hit), 32'd1);
            check32("post_instr", Instr_2IF, model_word(a));
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] base;
        m_miss   = 32'd0;
        RESET    = 1'b0;
        Flush    = 1'b0;
        Mem_Ack  = 1'b0;
        Mem_Data = 32'd0;
        Addr_fIF = 32'hBFC0_0000;
        #2;
        check32("rst_hit", 32'(hit), 32'd0);
        check32("rst_req", 32'(Mem_Req), 32'd0);
        check32("rst_addr", Mem_Addr, 32'd0);
        check32("rst_miss", Miss_Count, 32'd0);
        tick();
        tick();
        RESET = 1'b1;

        // Cold miss with known words
        lbuf[0] = 32'h11; lbuf[1] = 32'h22; lbuf[2] = 32'h33; lbuf[3] = 32'h44;
        access(32'hBFC0_0000, 0, 0, 1'b1);
        check32("cold_instr0", Instr_2IF, 32'h11);
        Addr_fIF = 32'hBFC0_0008;
        #1;
        check32("cold_hit8", 32'(hit), 32'd1);
        check32("cold_instr8", Instr_2IF, 32'h33);
        check32("cold_count", Miss_Count, 32'd1);

        // Acks while idle are ignored
        Addr_fIF = 32'hBFC0_0004;
        Mem_Ack  = 1'b1;
        Mem_Data = 32'hDEAD_BEEF;
        tick();
        Mem_Ack  = 1'b0;
        check32("idle_ack_req", 32'(Mem_Req), 32'd0);
        check32("idle_ack_instr", Instr_2IF, 32'h22);

        // Conflict on index 0
        access(32'hBFC0_0400, 0, 1, 1'b0);
        check32("conflict_count", Miss_Count, 32'd2);
        access(32'hBFC0_0000, 0, 1, 1'b0);

        // Ack gaps of 3 idle cycles
        access(32'hBFC0_0104, 3, 3, 1'b0);

        // Flush mid-refill
        a = 32'h0000_1230;
        base = a - (a % 16);
        fill_lbuf();
        begin_refill(a);
        serve_word(base, 0, 0, 1'b0);
        serve_word(base, 1, 0, 1'b0);
        Flush = 1'b1;
        #1;
        check32("flush_hit", 32'(hit), 32'd0);
        check32("flush_req", 32'(Mem_Req), 32'd1);
        tick();
        Flush = 1'b0;
        model_flush();
        serve_word(base, 2, 1, 1'b0);
        serve_word(base, 3, 0, 1'b0);
        finish_refill(a, 1'b1);
        check32("flushed_line", 32'(hit), 32'd0);
        access(a, 0, 1, 1'b0);

        // Redirect mid-refill
        a = 32'hBFC0_0000;
        fill_lbuf();
        begin_refill(a);
        serve_word(a, 0, 0, 1'b0);
        Addr_fIF = 32'h8000_0020;
        serve_word(a, 1, 1, 1'b0);
        serve_word(a, 2, 0, 1'b0);
        serve_word(a, 3, 0, 1'b0);
        finish_refill(a, 1'b0);
        access(32'h8000_0020, 0, 1, 1'b0);
        access(32'hBFC0_000C, 0, 0, 1'b0);

        // Flush coincident with the final ack
        a = 32'h0000_2040;
        fill_lbuf();
        begin_refill(a);
        for (int w = 0; w < LW - 1; w++) serve_word(a, w, 0, 1'b0);
        serve_word(a, LW - 1, 0, 1'b1);
        model_flush();
        finish_refill(a, 1'b1);
        check32("final_flush_hit", 32'(hit), 32'd0);

        // Randomized accesses over a small conflicting address pool
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(2, 0))
                0: a = 32'hBFC0_0000;
                1: a = 32'h8000_0000;
                default: a = 32'h0040_0000;
            endcase
            a = a + 32'($urandom_range(3, 0) * 16) + 32'($urandom_range(3, 0) * 4);
            if ($urandom_range(7, 0) == 0) begin
                Addr_fIF = a;
                Flush = 1'b1;
                #1;
                check32("idle_flush_hit", 32'(hit), 32'd0);
                tick();
                Flush = 1'b0;
                model_flush();
                check32("idle_flush_req", 32'(Mem_Req), 32'd0);
                check32("idle_flush_count", Miss_Count, m_miss);
            end
            access(a, 0, 2, 1'b0);
        end

        // Reset mid-refill
        a = 32'hBFC0_0010;
        fill_lbuf();
        begin_refill(a);
        serve_word(a, 0, 0, 1'b0);
        serve_word(a, 1, 0, 1'b0);
        RESET = 1'b0;
        #1;
        check32("arst_req", 32'(Mem_Req), 32'd0);
        check32("arst_addr", Mem_Addr, 32'd0);
        check32("arst_count", Miss_Count, 32'd0);
        check32("arst_hit", 32'(hit), 32'd0);
        model_flush();
        m_miss = 32'd0;
        tick();
        RESET = 1'b1;
        access(32'hBFC0_0000, 0, 1, 1'b0);
        access(a, 0, 1, 1'b0);
        check32("final_count", Miss_Count, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
